// File: rtl/game_pkg.sv
// Shared game types: tile encoding, default queue depth and the bag index -> tile mapping.
package game_pkg;

   typedef enum logic [2:0] {
      TILE_BLANK = 3'd0,
      TILE_I     = 3'd1,
      TILE_O     = 3'd2,
      TILE_T     = 3'd3,
      TILE_J     = 3'd4,
      TILE_L     = 3'd5,
      TILE_S     = 3'd6,
      TILE_Z     = 3'd7
   } tile_type_t;

   localparam int NEXT_PIECES_COUNT = 5;

   localparam tile_type_t BAG_ORDER [7] = '{TILE_I, TILE_O, TILE_T, TILE_J, TILE_L, TILE_S, TILE_Z};

   // Reduce a value in 0..13 to 0..6 without a modulo operator.
   function automatic logic [2:0] wrap7(input logic [3:0] v);
      logic [3:0] t;
      t = (v >= 4'd7) ? (v - 4'd7) : v;
      return t[2:0];
   endfunction

endpackage

// File: rtl/seven_bag_gen.sv
// 7-bag piece generator: 16-bit Galois LFSR picks a start index, the bag mask skips used pieces.
// NEXT_QUEUE_FIXED_SEQ_EN forces the start index to 0, giving I,O,T,J,L,S,Z repeating.
module seven_bag_gen
   import game_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       advance,
   output tile_type_t piece
);

   // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [15:0] SEED_SAFE = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

   logic [15:0] lfsr_r;
   logic [6:0]  mask_r;
   logic [6:0]  mask_next_s;
   logic [2:0]  start_s;
   logic [2:0]  cand_s;
   logic [2:0]  idx_s;
   logic        found_s;

   // Start index of the search, taken from the LFSR unless the fixed sequence is built in.
   always_comb begin
`ifdef NEXT_QUEUE_FIXED_SEQ_EN
      start_s = 3'd0;
`else
      start_s = (lfsr_r[2:0] == 3'd7) ? 3'd0 : lfsr_r[2:0];
`endif
   end

   // First unused bag index at or after the start index, wrapping mod 7.
   always_comb begin
      idx_s   = start_s;
      cand_s  = start_s;
      found_s = 1'b0;
      for (int k = 0; k < 7; k++) begin
         cand_s = wrap7({1'b0, start_s} + 4'(k));
         if (!found_s && !mask_r[cand_s]) begin
            idx_s   = cand_s;
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Mark the chosen piece; a completed bag clears immediately so the next bag starts.
   always_comb begin
      mask_next_s = mask_r | (7'd1 << idx_s);
      if (mask_next_s == 7'h7F) begin
         mask_next_s = 7'h00;
      end else begin
         mask_next_s = mask_next_s;
      end
   end

   assign piece = BAG_ORDER[idx_s];

   // LFSR runs every non-reset cycle; mask only moves when a piece is consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_r <= SEED_SAFE;
         mask_r <= 7'h00;
      end else begin
         lfsr_r <= lfsr_r[0] ? ((lfsr_r >> 1) ^ LFSR_TAPS) : (lfsr_r >> 1);
         if (advance) begin
            mask_r <= mask_next_s;
         end else begin
            mask_r <= mask_r;
         end
      end
   end

endmodule

// File: rtl/next_piece_queue.sv
// Upcoming-piece shift queue fed by seven_bag_gen; head at entry 0, shift-on-pop.
// Define NEXT_QUEUE_FIXED_SEQ_EN for the deterministic I,O,T,J,L,S,Z sequence.
module next_piece_queue
   import game_pkg::*;
#(
   parameter int          QUEUE_DEPTH = NEXT_PIECES_COUNT,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pop,
   output tile_type_t pieces_queue [QUEUE_DEPTH],
   output logic       queue_ready
);

   localparam int             CW      = $clog2(QUEUE_DEPTH + 1);
   localparam logic [CW-1:0]  DEPTH_C = CW'(QUEUE_DEPTH);

   tile_type_t    entry_r [QUEUE_DEPTH];
   logic [CW-1:0] count_r;
   logic          ready_r;
   logic          pop_ok_s;
   logic          push_s;
   tile_type_t    gen_s;

   assign pop_ok_s = pop & ready_r;
   assign push_s   = (count_r < DEPTH_C) | pop_ok_s;

   seven_bag_gen #(
      .LFSR_SEED (LFSR_SEED)
   ) u_gen (
      .clk     (clk),
      .rst     (rst),
      .advance (push_s),
      .piece   (gen_s)
   );

   // Queue storage: fill at the tail while not full, shift and refill the last slot on a pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < QUEUE_DEPTH; k++) begin
            entry_r[k] <= TILE_BLANK;
         end
         count_r <= '0;
         ready_r <= 1'b0;
      end else if (pop_ok_s) begin
         for (int k = 0; k < QUEUE_DEPTH - 1; k++) begin
            entry_r[k] <= entry_r[k+1];
         end
         entry_r[QUEUE_DEPTH-1] <= gen_s;
         count_r <= count_r;
         ready_r <= 1'b1;
      end else if (push_s) begin
         for (int k = 0; k < QUEUE_DEPTH; k++) begin
            if (CW'(k) == count_r) begin
               entry_r[k] <= gen_s;
            end else begin
               entry_r[k] <= entry_r[k];
            end
         end
         count_r <= count_r + CW'(1);
         ready_r <= ((count_r + CW'(1)) == DEPTH_C);
      end else begin
         count_r <= count_r;
         ready_r <= ready_r;
      end
   end

   assign pieces_queue = entry_r;
   assign queue_ready  = ready_r;

endmodule
